// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit-side blocks.
//   UART_DATA_W    - width of one UART character
//   tx_buf_state_t - transmit sequencer states used by uart_tx_buffer
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT
  } tx_buf_state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: DEPTH x UART_DATA_W byte store with pointer and level tracking.
// Ports:
//   clka, reset       - clock, synchronous active-high reset
//   wr_en, wr_data    - host write; ignored (and overflow set) while full
//   pop               - advance the read pointer (ignored while empty)
//   rd_data           - entry at the read pointer (the consumer registers it)
//   level, full, empty, overflow - occupancy status; overflow is sticky
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic                   clka,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [UART_DATA_W-1:0] wr_data,
  input  logic                   pop,
  output logic [UART_DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]        level,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow
);

  localparam logic [ADDR_W:0] LEVEL_FULL = (ADDR_W+1)'(DEPTH);

  logic [UART_DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]      wr_ptr;
  logic [ADDR_W-1:0]      rd_ptr;
  logic                   wr_ok;
  logic                   pop_ok;

  // Flags come straight from the registered level, so a pop frees its slot
  // only from the following cycle.
  assign full    = (level == LEVEL_FULL);
  assign empty   = (level == '0);
  assign wr_ok   = wr_en && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clka) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clka) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      unique case ({wr_ok, pop_ok})
        2'b10:   level <= level + (ADDR_W+1)'(1);
        2'b01:   level <= level - (ADDR_W+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: byte FIFO plus transmit sequencer in front of a UART.
// Bytes are presented one at a time on tx_data/tx_rdy; a byte is popped on
// tx_done, retried on tx_error up to MAX_RETRY times, then dropped.
// Ports:
//   clka, reset                 - clock, synchronous active-high reset
//   wr_en, wr_data              - host write strobe and byte
//   full, empty, level          - buffer occupancy
//   overflow                    - sticky, write attempted while full
//   tx_data, tx_rdy             - byte and request towards the UART
//   tx_busy, tx_done, tx_error  - UART responses
//   drop                        - one-cycle pulse when a byte is discarded
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned ADDR_W    = 3,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic                   clka,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [UART_DATA_W-1:0] wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [ADDR_W:0]        level,
  output logic                   overflow,
  output logic [UART_DATA_W-1:0] tx_data,
  output logic                   tx_rdy,
  input  logic                   tx_busy,
  input  logic                   tx_done,
  input  logic                   tx_error,
  output logic                   drop
);

  localparam int unsigned         RETRY_W     = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RETRY_W-1:0]  RETRY_LIMIT = RETRY_W'(MAX_RETRY);

  tx_buf_state_t          state;
  logic [RETRY_W-1:0]     retry_cnt;
  logic [UART_DATA_W-1:0] rd_data;
  logic                   active;
  logic                   fail;
  logic                   success;
  logic                   retries_left;
  logic                   give_up;
  logic                   pop;

  uart_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clka     (clka),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .pop      (pop),
    .rd_data  (rd_data),
    .level    (level),
    .full     (full),
    .empty    (empty),
    .overflow (overflow)
  );

  // SEND resolves done/error exactly like WAIT so a UART without a busy
  // phase still works; error takes priority over done.
  always_comb begin
    active       = (state != IDLE);
    retries_left = (retry_cnt < RETRY_LIMIT);
    fail         = active && tx_error;
    success      = active && tx_done && !tx_error;
    give_up      = fail && !retries_left;
    pop          = success || give_up;
  end

  always_ff @(posedge clka) begin
    if (reset) begin
      state     <= IDLE;
      tx_rdy    <= 1'b0;
      tx_data   <= '0;
      drop      <= 1'b0;
      retry_cnt <= '0;
    end else begin
      drop <= 1'b0;
      unique case (state)
        IDLE: begin
          tx_rdy <= 1'b0;
          if (!empty) begin
            tx_data <= rd_data;
            tx_rdy  <= 1'b1;
            state   <= SEND;
          end
        end
        SEND, WAIT: begin
          if (fail && retries_left) begin
            retry_cnt <= retry_cnt + RETRY_W'(1);
            tx_rdy    <= 1'b1;
            state     <= SEND;
          end else if (pop) begin
            retry_cnt <= '0;
            tx_rdy    <= 1'b0;
            drop      <= give_up;
            state     <= IDLE;
          end else if (state == SEND && tx_busy) begin
            tx_rdy <= 1'b0;
            state  <= WAIT;
          end
        end
        default: begin
          tx_rdy <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffer.sv
module tb_uart_tx_buffer;

  logic       clka = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [3:0] level;
  logic       overflow;
  logic [7:0] tx_data;
  logic       tx_rdy;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;
  logic       drop;

  int total = 0;
  int bad   = 0;

  logic [7:0] sb_q[$];
  int         exp_level;

  always #5 clka = ~clka;

  uart_tx_buffer #(
    .DEPTH     (8),
    .ADDR_W    (3),
    .MAX_RETRY (2)
  ) dut (
    .clka     (clka),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow),
    .tx_data  (tx_data),
    .tx_rdy   (tx_rdy),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .tx_error (tx_error),
    .drop     (drop)
  );

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] e_level;
    logic       e_rdy;
    logic [7:0] e_data;
    logic       e_drop;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic wr, input logic [7:0] d, input logic busy,
                              input logic done, input logic err, input logic [3:0] e_level,
                              input logic e_rdy, input logic [7:0] e_data, input logic e_drop);
    vec_t v;
    v.wr = wr; v.d = d; v.busy = busy; v.done = done; v.err = err;
    v.e_level = e_level; v.e_rdy = e_rdy; v.e_data = e_data; v.e_drop = e_drop;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are observed there too.
  task automatic cyc();
    @(posedge clka);
    @(negedge clka);
  endtask

  task automatic clear_in();
    wr_en = 1'b0; wr_data = 8'h00; tx_busy = 1'b0; tx_done = 1'b0; tx_error = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d;
    cyc();
    clear_in();
  endtask

  task automatic wait_rdy(input string name);
    int n = 0;
    while (tx_rdy !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    if (tx_rdy !== 1'b1) check(name, {31'b0, tx_rdy}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_in();
    reset = 1'b1;
    cyc();
    check("rst_rdy",   {31'b0, tx_rdy},   0);
    check("rst_data",  {24'b0, tx_data},  0);
    check("rst_drop",  {31'b0, drop},     0);
    check("rst_ovf",   {31'b0, overflow}, 0);
    check("rst_level", {28'b0, level},    0);
    check("rst_empty", {31'b0, empty},    1);
    check("rst_full",  {31'b0, full},     0);
    reset = 1'b0;

    // wr d busy done err | level rdy data drop
    vt.push_back(mk(1, 8'hE8, 0, 0, 0, 1, 0, 8'h00, 0));
    vt.push_back(mk(0, 8'h00, 0, 0, 0, 1, 1, 8'hE8, 0));
    vt.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, 8'hE8, 0));
    vt.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 8'hE8, 0));
    vt.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 8'hE8, 0));
    // 0x55: three errors -> two retries then drop
    vt.push_back(mk(1, 8'h55, 0, 0, 0, 1, 0, 8'hE8, 0));
    vt.push_back(mk(0, 8'h00, 0, 0, 0, 1, 1, 8'h55, 0));
    vt.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, 8'h55, 0));
    vt.push_back(mk(0, 8'h00, 0, 0, 1, 1, 1, 8'h55, 0));
    vt.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, 8'h55, 0));
    vt.push_back(mk(0, 8'h00, 0, 0, 1, 1, 1, 8'h55, 0));
    vt.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, 8'h55, 0));
    vt.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 8'h55, 1));
    vt.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 8'h55, 0));
    // 0xAA: one error then done
    vt.push_back(mk(1, 8'hAA, 0, 0, 0, 1, 0, 8'h55, 0));
    vt.push_back(mk(0, 8'h00, 0, 0, 0, 1, 1, 8'hAA, 0));
    vt.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, 8'hAA, 0));
    vt.push_back(mk(0, 8'h00, 0, 0, 1, 1, 1, 8'hAA, 0));
    vt.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, 8'hAA, 0));
    vt.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 8'hAA, 0));
    vt.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 8'hAA, 0));
    // 0x3C: done straight from SEND, no busy phase
    vt.push_back(mk(1, 8'h3C, 0, 0, 0, 1, 0, 8'hAA, 0));
    vt.push_back(mk(0, 8'h00, 0, 0, 0, 1, 1, 8'h3C, 0));
    vt.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 8'h3C, 0));
    // 0x5A: error wins over done, errors in SEND count, then drop
    vt.push_back(mk(1, 8'h5A, 0, 0, 0, 1, 0, 8'h3C, 0));
    vt.push_back(mk(0, 8'h00, 0, 0, 0, 1, 1, 8'h5A, 0));
    vt.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, 8'h5A, 0));
    vt.push_back(mk(0, 8'h00, 0, 1, 1, 1, 1, 8'h5A, 0));
    vt.push_back(mk(0, 8'h00, 0, 1, 1, 1, 1, 8'h5A, 0));
    vt.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 8'h5A, 1));
    vt.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 8'h5A, 0));
    // responses are ignored in IDLE
    vt.push_back(mk(0, 8'h00, 1, 1, 1, 0, 0, 8'h5A, 0));

    for (int i = 0; i < vt.size(); i++) begin
      wr_en = vt[i].wr; wr_data = vt[i].d;
      tx_busy = vt[i].busy; tx_done = vt[i].done; tx_error = vt[i].err;
      cyc();
      clear_in();
      check($sformatf("vec%0d_level", i), {28'b0, level},   {28'b0, vt[i].e_level});
      check($sformatf("vec%0d_empty", i), {31'b0, empty},   {31'b0, vt[i].e_level == 4'd0});
      check($sformatf("vec%0d_rdy", i),   {31'b0, tx_rdy},  {31'b0, vt[i].e_rdy});
      check($sformatf("vec%0d_data", i),  {24'b0, tx_data}, {24'b0, vt[i].e_data});
      check($sformatf("vec%0d_drop", i),  {31'b0, drop},    {31'b0, vt[i].e_drop});
    end
    check("tbl_ovf", {31'b0, overflow}, 0);

    // Fill to capacity, then one write too many.
    exp_level = 0;
    for (int i = 1; i <= 9; i++) begin
      if (exp_level < 8) begin
        sb_q.push_back(8'(i));
        exp_level++;
      end
      write_byte((i == 9) ? 8'hFF : 8'(i));
    end
    check("fill_full",  {31'b0, full},     1);
    check("fill_ovf",   {31'b0, overflow}, 1);
    check("fill_level", {28'b0, level},    32'(exp_level));

    // Drain; the first pop coincides with a write that full must still block.
    for (int k = 0; k < 8; k++) begin
      wait_rdy("drain_rdy_timeout");
      check($sformatf("drain%0d_data", k), {24'b0, tx_data}, {24'b0, sb_q[0]});
      if (k % 2 == 1) begin
        tx_busy = 1'b1;
        cyc();
        clear_in();
      end
      if (k == 0) begin
        wr_en = 1'b1; wr_data = 8'hEE;
      end
      tx_done = 1'b1;
      cyc();
      clear_in();
      void'(sb_q.pop_front());
      exp_level--;
      check($sformatf("drain%0d_level", k), {28'b0, level}, 32'(exp_level));
    end
    cyc(); cyc();
    check("drain_empty", {31'b0, empty},  1);
    check("drain_rdy",   {31'b0, tx_rdy}, 0);

    // Simultaneous write and pop at level 3; pointers wrap.
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(8'h10 + 8'(i));
      write_byte(8'h10 + 8'(i));
    end
    check("pair_start_level", {28'b0, level}, 3);
    for (int i = 0; i < 10; i++) begin
      wait_rdy("pair_rdy_timeout");
      check($sformatf("pair%0d_data", i), {24'b0, tx_data}, {24'b0, sb_q[0]});
      wr_en = 1'b1; wr_data = 8'h20 + 8'(i); tx_done = 1'b1;
      cyc();
      clear_in();
      void'(sb_q.pop_front());
      sb_q.push_back(8'h20 + 8'(i));
      check($sformatf("pair%0d_level", i), {28'b0, level}, 3);
    end
    for (int k = 0; k < 3; k++) begin
      wait_rdy("tail_rdy_timeout");
      check($sformatf("tail%0d_data", k), {24'b0, tx_data}, {24'b0, sb_q[0]});
      tx_done = 1'b1;
      cyc();
      clear_in();
      void'(sb_q.pop_front());
    end
    check("tail_level", {28'b0, level}, 0);

    // Reset while in WAIT with four bytes stored.
    for (int i = 0; i < 4; i++) write_byte(8'h40 + 8'(i));
    wait_rdy("rst_wait_rdy_timeout");
    tx_busy = 1'b1;
    cyc();
    clear_in();
    check("prerst_rdy",   {31'b0, tx_rdy},   0);
    check("prerst_level", {28'b0, level},    4);
    check("prerst_ovf",   {31'b0, overflow}, 1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("midrst_rdy",   {31'b0, tx_rdy},   0);
    check("midrst_level", {28'b0, level},    0);
    check("midrst_ovf",   {31'b0, overflow}, 0);
    check("midrst_empty", {31'b0, empty},    1);
    check("midrst_data",  {24'b0, tx_data},  0);
    cyc(); cyc(); cyc();
    check("postrst_rdy",  {31'b0, tx_rdy},   0);
    write_byte(8'h77);
    cyc();
    check("postrst_send_rdy",  {31'b0, tx_rdy},  1);
    check("postrst_send_data", {24'b0, tx_data}, 8'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
